cipher_uart_tx: RTL and testbench

Downstream consumer of the Enigma datapath's encrypted letter.
- Captures each 5-bit ciphertext letter (0=A … 25=Z) on a one-cycle strobe and buffers it in a small FIFO.
- Converts each letter to ASCII and transmits it as 8N1 UART, LSB first, so an attached terminal logs the ciphertext stream.
- Sits beside the seven-segment path and taps the same inverse-plugboard output the display uses.
- The strobe is the debounced, validated enter pulse delayed one cycle, so the rotor step has settled.

---
 rtl/cipher_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_cipher_uart_tx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_uart_tx.sv
// Buffers Enigma ciphertext letters and sends them as ASCII over 8N1 UART.
// Define GROUP5_EN to insert a space frame after every fifth letter.
module cipher_uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DEPTH        = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [4:0]               LET,
  input  logic                     VALID,
  output logic                     TX,
  output logic                     BUSY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef GROUP5_EN
    ,
    SPACE_START,
    SPACE_DATA,
    SPACE_STOP
`endif
  } state_t;

  state_t          state, state_n;
  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            ovf;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      byte_q, byte_n;
  logic            pop, wr, let_ok, bit_end;
`ifdef GROUP5_EN
  logic [2:0]      group, group_n;
`endif

  assign FULL    = (count == CMAX);
  assign COUNT   = count;
  assign OVF     = ovf;
  assign BUSY    = (state != IDLE);
  assign let_ok  = (LET <= 5'd25);
  assign pop     = (state == IDLE) && (count != '0);
  // A full FIFO still accepts when the head leaves on the same edge
  assign wr      = VALID && let_ok && (!FULL || pop);
  assign bit_end = (baud == BMAX);

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= LET;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
      if (VALID && !wr) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      baud   <= '0;
      idx    <= '0;
      byte_q <= '0;
`ifdef GROUP5_EN
      group  <= '0;
`endif
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      idx    <= idx_n;
      byte_q <= byte_n;
`ifdef GROUP5_EN
      group  <= group_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    idx_n   = idx;
    byte_n  = byte_q;
`ifdef GROUP5_EN
    group_n = group;
`endif
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (count != '0) begin
          state_n = START;
          byte_n  = 8'h41 + {3'b000, mem[rptr]};
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = IDLE;
`ifdef GROUP5_EN
          if (group == 3'd4) begin
            state_n = SPACE_START;
            group_n = '0;
            byte_n  = 8'h20;
          end else begin
            group_n = group + 3'd1;
          end
`endif
        end
      end
`ifdef GROUP5_EN
      SPACE_START: begin
        if (bit_end) begin
          state_n = SPACE_DATA;
          baud_n  = '0;
          idx_n   = '0;
        end
      end
      SPACE_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (idx == 3'd7) state_n = SPACE_STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      SPACE_STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        baud_n  = '0;
      end
    endcase
  end

  always_comb begin
    TX = 1'b1;
    unique case (state)
      START: TX = 1'b0;
      DATA:  TX = byte_q[idx];
`ifdef GROUP5_EN
      SPACE_START: TX = 1'b0;
      SPACE_DATA:  TX = byte_q[idx];
`endif
      default: TX = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Directed bench for cipher_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// Build with the same GROUP5_EN setting as the RTL.
module tb_cipher_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       VALID = 1'b0;
  logic [4:0] LET = '0;
  logic       TX, BUSY, FULL, OVF;
  logic [2:0] COUNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cipher_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .LET(LET),
    .VALID(VALID),
    .TX(TX),
    .BUSY(BUSY),
    .FULL(FULL),
    .COUNT(COUNT),
    .OVF(OVF)
  );

  task automatic pulse(input logic [4:0] l);
    @(negedge CLK);
    VALID = 1'b1;
    LET   = l;
    @(negedge CLK);
    VALID = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = '0;
    @(negedge CLK);
    while (TX !== 1'b0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (TX !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge CLK);
      b[i] = TX;
    end
    repeat (CPB) @(negedge CLK);
    if (TX !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({TX, BUSY, FULL, COUNT, OVF} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset got %b want 1000000",
               {TX, BUSY, FULL, COUNT, OVF});
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_single();
    logic [9:0] frame;
    frame = 10'b1_0100_0001_0;
    pulse(5'd0);
    checks++;
    if (COUNT !== 3'd1 || BUSY !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL single_wr got cnt=%0d busy=%b tx=%b want 1 0 1",
               COUNT, BUSY, TX);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        checks++;
        if (COUNT !== 3'd0 || BUSY !== 1'b1) begin
          errors++;
          $display("FAIL single_pop got cnt=%0d busy=%b want 0 1",
                   COUNT, BUSY);
        end
      end
      checks++;
      if (TX !== frame[k/4]) begin
        errors++;
        $display("FAIL single_tx cyc %0d got %b want %b",
                 k, TX, frame[k/4]);
      end
    end
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL single_end got busy=%b tx=%b want 0 1", BUSY, TX);
    end
  endtask

  task automatic test_invalid();
    bit bad;
    bad = 1'b0;
    pulse(5'd27);
    checks++;
    if (COUNT !== 3'd0 || OVF !== 1'b1) begin
      errors++;
      $display("FAIL invalid got cnt=%0d ovf=%b want 0 1", COUNT, OVF);
    end
    repeat (8) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || TX !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL invalid_line got activity want idle");
    end
  endtask

  task automatic test_reset_mid_frame();
    bit bad;
    bad = 1'b0;
    pulse(5'd2);
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || OVF !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b ovf=%b want 1 1", BUSY, OVF);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({TX, BUSY, COUNT, OVF} !== 6'b100000) begin
      errors++;
      $display("FAIL midrst got %b want 100000",
               {TX, BUSY, COUNT, OVF});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (60) begin
      @(negedge CLK);
      if (TX !== 1'b1 || BUSY !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_after got frame want idle");
    end
  endtask

  task automatic test_overflow();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge CLK);
          if (i == 5) begin
            checks++;
            if (COUNT !== 3'd4 || FULL !== 1'b1 || OVF !== 1'b0) begin
              errors++;
              $display("FAIL ovf_full got c=%0d f=%b o=%b want 4 1 0",
                       COUNT, FULL, OVF);
            end
          end
          VALID = 1'b1;
          LET   = 5'(i);
        end
        @(negedge CLK);
        VALID = 1'b0;
        checks++;
        if (OVF !== 1'b1 || COUNT !== 3'd4) begin
          errors++;
          $display("FAIL ovf_drop got o=%b c=%0d want 1 4", OVF, COUNT);
        end
      end
      begin
        logic [7:0] b;
        bit ok;
        for (int j = 0; j < 5; j++) begin
          rx_byte(b, ok);
          checks++;
          if (!ok || b !== 8'h41 + 8'(j)) begin
            errors++;
            $display("FAIL ovf_rx %0d got %h ok=%b want %h",
                     j, b, ok, 8'h41 + 8'(j));
          end
        end
      end
    join
    checks++;
    if (COUNT !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drain got %0d want 0", COUNT);
    end
  endtask

  task automatic test_full_pop();
    int n;
    logic [7:0] exp[$];
    logic [7:0] b;
    bit ok;
`ifdef GROUP5_EN
    exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46};
`else
    exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      VALID = 1'b1;
      LET   = 5'(i);
    end
    @(negedge CLK);
    VALID = 1'b0;
    checks++;
    if (COUNT !== 3'd4 || FULL !== 1'b1 || OVF !== 1'b0) begin
      errors++;
      $display("FAIL fp_fill got c=%0d f=%b o=%b want 4 1 0",
               COUNT, FULL, OVF);
    end
    n = 0;
    while (BUSY !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL fp_idle got busy=%b want 0", BUSY);
    end
    VALID = 1'b1;
    LET   = 5'd5;
    @(negedge CLK);
    VALID = 1'b0;
    checks++;
    if (COUNT !== 3'd4 || OVF !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL fp_same got c=%0d o=%b b=%b want 4 0 1",
               COUNT, OVF, BUSY);
    end
    foreach (exp[j]) begin
      rx_byte(b, ok);
      checks++;
      if (!ok || b !== exp[j]) begin
        errors++;
        $display("FAIL fp_rx %0d got %h ok=%b want %h",
                 j, b, ok, exp[j]);
      end
    end
  endtask

  task automatic test_group();
    logic [7:0] exp[$];
    bit bad;
`ifdef GROUP5_EN
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47};
`else
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
`endif
    bad = 1'b0;
    fork
      begin
        int n;
        for (int i = 0; i < 7; i++) begin
          n = 0;
          @(negedge CLK);
          while (FULL === 1'b1 && n < 500) begin
            @(negedge CLK);
            n++;
          end
          VALID = 1'b1;
          LET   = 5'(i);
          @(negedge CLK);
          VALID = 1'b0;
        end
      end
      begin
        logic [7:0] b;
        bit ok;
        foreach (exp[j]) begin
          rx_byte(b, ok);
          checks++;
          if (!ok || b !== exp[j]) begin
            errors++;
            $display("FAIL grp_rx %0d got %h ok=%b want %h",
                     j, b, ok, exp[j]);
          end
        end
      end
    join
    repeat (60) begin
      @(negedge CLK);
      if (TX !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || BUSY !== 1'b0 || OVF !== 1'b0) begin
      errors++;
      $display("FAIL grp_tail got extra=%b busy=%b ovf=%b want 0 0 0",
               bad, BUSY, OVF);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_invalid();
    test_reset_mid_frame();
    test_overflow();
    do_reset();
    test_full_pop();
    do_reset();
    test_group();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
